sw_debounce4: RTL and testbench

Four-channel switch conditioner that sits directly upstream of the `a/b/c/d` combinational logic stage. It synchronises four raw board switch inputs into the clock domain and debounces each one independently. It then presents clean, stable levels on `sw_out[3:0]`, which feed logic inputs `a..d`. It also emits one-cycle rise/fall strobes so downstream sequential logic can react to each change exactly once.

---
 rtl/sw_debounce4.sv | 93 +++++++++
 tb/tb_sw_debounce4.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce4.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce4
//  Description : Four-channel switch conditioner. Each raw switch input is
//                brought into the clk domain through a two-flop synchroniser
//                and then debounced by a per-channel stability counter. The
//                block presents clean registered levels plus one-cycle
//                rise/fall strobes and a combined "changed" strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce4 #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_in,
    output logic [3:0] sw_out,
    output logic [3:0] rise,
    output logic [3:0] fall,
    output logic       changed
);

    localparam int               C_NCH      = 4;
    // Terminal count: the input must have disagreed with sw_out on this many
    // previous edges (plus the current one) before the new level is adopted.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [C_NCH-1:0] sync1_q,   sync1_d;
    logic [C_NCH-1:0] sync2_q,   sync2_d;
    logic [C_NCH-1:0] sw_out_q,  sw_out_d;
    logic [C_NCH-1:0] rise_q,    rise_d;
    logic [C_NCH-1:0] fall_q,    fall_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [C_NCH];
    logic [CNT_W-1:0] cnt_d [C_NCH];

    // Next-state: synchroniser shift, per-channel stability counting and strobes
    always_comb begin
        sync1_d  = sw_in;
        sync2_d  = sync1_q;
        sw_out_d = sw_out_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < C_NCH; i++) begin
            // Agreement with the current level (a bounce back) clears the
            // window, so only an unbroken run of disagreement can update.
            cnt_d[i] = '0;
            if (sync2_q[i] != sw_out_q[i]) begin
                if (cnt_q[i] == C_CNT_LAST) begin
                    sw_out_d[i] = sync2_q[i];
                    rise_d[i]   = sync2_q[i];
                    fall_d[i]   = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        changed_d = |{rise_d, fall_d};
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sw_out_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < C_NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sw_out_q  <= sw_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < C_NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_out  = sw_out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_debounce4
//  Description : Self-checking bench for sw_debounce4 (DEB_CYCLES=4, CNT_W=4).
//                Directed vector table, hand-written reset sequences and a
//                randomized run compared against a sliding-window model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debounce4;

    localparam int DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_in;
    logic [3:0] sw_out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;

    int n_vec;
    int n_err;

    sw_debounce4 #(.DEB_CYCLES(DEB), .CNT_W(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_in   (sw_in),
        .sw_out  (sw_out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    // The debounced level adopts the synchronised input once the last DEB
    // synchronised samples all disagree with it. Synchronised input is the
    // raw input as sampled two edges earlier (zero right after reset).
    logic [3:0] m_dly [2];
    logic [3:0] m_win [DEB];
    logic [3:0] m_out;
    logic [3:0] m_rise;
    logic [3:0] m_fall;

    task automatic model_reset();
        m_dly[0] = '0;
        m_dly[1] = '0;
        for (int j = 0; j < DEB; j++) m_win[j] = '0;
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
    endtask

    task automatic model_edge(input logic [3:0] v);
        logic [3:0] s;
        logic [3:0] nxt;
        s = m_dly[1];
        m_dly[1] = m_dly[0];
        m_dly[0] = v;
        for (int j = DEB - 1; j > 0; j--) m_win[j] = m_win[j-1];
        m_win[0] = s;
        nxt = m_out;
        for (int c = 0; c < 4; c++) begin
            bit all_differ;
            all_differ = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (m_win[j][c] == m_out[c]) all_differ = 1'b0;
            if (all_differ) nxt[c] = ~m_out[c];
        end
        m_rise = nxt & ~m_out;
        m_fall = m_out & ~nxt;
        m_out  = nxt;
    endtask

    // ---------------------------------------------------------------- checks
    task automatic chk(input string name, input logic [3:0] eo, input logic [3:0] er,
                       input logic [3:0] ef, input logic ec);
        n_vec++;
        if (sw_out !== eo || rise !== er || fall !== ef || changed !== ec) begin
            n_err++;
            $display("FAIL %s @%0t: got out=%h rise=%h fall=%h chg=%b, expected out=%h rise=%h fall=%h chg=%b",
                     name, $time, sw_out, rise, fall, changed, eo, er, ef, ec);
        end
    endtask

    task automatic chk_model(input string name);
        chk(name, m_out, m_rise, m_fall, |{m_rise, m_fall});
    endtask

    // One clock: drive input, let the edge happen, step model, compare.
    task automatic step(input logic [3:0] v);
        sw_in = v;
        @(posedge clk);
        model_edge(v);
        #1;
        chk_model("model");
    endtask

    // Assert reset between edges, verify immediate clear, hold n edges, release.
    task automatic hold_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset_async", 4'h0, 4'h0, 4'h0, 1'b0);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", 4'h0, 4'h0, 4'h0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- table
    typedef struct {
        logic [3:0] in;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t tbl[$];

    // n rows of one input; the level moves from ob to oa on row upd (-1: never)
    task automatic seg(input logic [3:0] in, input int n, input int upd,
                       input logic [3:0] ob, input logic [3:0] oa);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.in = in;
            if (upd < 0 || i < upd) begin
                v.out = ob; v.rise = '0; v.fall = '0;
            end else if (i == upd) begin
                v.out = oa; v.rise = oa & ~ob; v.fall = ob & ~oa;
            end else begin
                v.out = oa; v.rise = '0; v.fall = '0;
            end
            tbl.push_back(v);
        end
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        logic [3:0] cur;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        sw_in = 4'h0;
        model_reset();

        // Reset with all inputs high, then debounce to 4'hF at edge k+5
        sw_in = 4'hF;
        hold_reset(2);
        for (int i = 0; i < 7; i++) begin
            step(4'hF);
            chk("rst_high", (i >= 5) ? 4'hF : 4'h0, (i == 5) ? 4'hF : 4'h0,
                4'h0, (i == 5));
        end

        // Directed table: clean step, bounce, simultaneous, falling edge
        seg(4'b0000, 3, -1, 4'b0000, 4'b0000);
        seg(4'b0001, 7,  5, 4'b0000, 4'b0001);
        for (int r = 0; r < 3; r++) begin
            seg(4'b0011, 3, -1, 4'b0001, 4'b0001);
            seg(4'b0001, 1, -1, 4'b0001, 4'b0001);
        end
        seg(4'b0011, 7,  5, 4'b0001, 4'b0011);
        seg(4'b1000, 7,  5, 4'b0011, 4'b1000);
        seg(4'b0100, 7,  5, 4'b1000, 4'b0100);
        seg(4'b1111, 7,  5, 4'b0100, 4'b1111);
        seg(4'b1111, 2, -1, 4'b1111, 4'b1111);
        seg(4'b0111, 1, -1, 4'b1111, 4'b1111);
        seg(4'b1111, 3, -1, 4'b1111, 4'b1111);
        seg(4'b0111, 7,  5, 4'b1111, 4'b0111);

        sw_in = 4'h0;
        hold_reset(1);
        foreach (tbl[i]) begin
            step(tbl[i].in);
            chk("table", tbl[i].out, tbl[i].rise, tbl[i].fall, |{tbl[i].rise, tbl[i].fall});
        end

        // Reset two cycles into a window on channel 2, release with input high
        sw_in = 4'h0;
        hold_reset(1);
        step(4'b0000);
        step(4'b0000);
        for (int i = 0; i < 4; i++) step(4'b0100);
        hold_reset(2);
        for (int i = 0; i < 7; i++) begin
            step(4'b0100);
            chk("rst_mid", (i >= 5) ? 4'b0100 : 4'b0000, (i == 5) ? 4'b0100 : 4'b0000,
                4'b0000, (i == 5));
        end

        // Randomized bouncing inputs with occasional mid-run resets
        cur = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
            if ($urandom_range(0, 399) == 0) begin
                sw_in = cur;
                hold_reset(int'($urandom_range(0, 2)));
            end
            step(cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
